slave_port: RTL and testbench

- Bus-side endpoint for one slave device on the serial bus; the downstream consumer of the master port's serial address/data stream once the address decoder has routed it.
- Deserialises the 12-bit memory address (LSB-first), then either receives 8 write-data bits or fetches read data from the local memory and serialises it back to the master.
- Optionally issues a split to the arbiter when local read latency is long, then drops split and resumes when the bus is regranted.

---
 rtl/bus_pkg.sv | 31 +++
 rtl/slave_port_if.sv | 36 +++
 rtl/serial_shift_rx.sv | 45 ++++
 rtl/slave_port.sv | 199 +++++++++++++++++++
 tb/tb_slave_port.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// Shared serial-bus definitions: FSM state codes, default widths and
// a counter-width helper used by the port FSMs and deserialisers.
package bus_pkg;

  localparam int BUS_DATA_WIDTH       = 8;
  localparam int SLAVE_MEM_ADDR_WIDTH = 12;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ADDR  = 3'd1;
  localparam logic [2:0] ST_WDATA = 3'd2;
  localparam logic [2:0] ST_MEMWR = 3'd3;
  localparam logic [2:0] ST_MEMRD = 3'd4;
  localparam logic [2:0] ST_SPLIT = 3'd5;
  localparam logic [2:0] ST_RDATA = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_ADDR  = ST_ADDR,
    S_WDATA = ST_WDATA,
    S_MEMWR = ST_MEMWR,
    S_MEMRD = ST_MEMRD,
    S_SPLIT = ST_SPLIT,
    S_RDATA = ST_RDATA
  } state_e;

  // At least one bit even for a limit of 1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/slave_port_if.sv
// Serial bus signals between the master side (via decoder/arbiter)
// and one slave port.
interface slave_port_if;

  logic swdata;
  logic smode;
  logic mvalid;
  logic split_grant;
  logic srdata;
  logic svalid;
  logic sready;
  logic ssplit;

  modport master (
    output swdata,
    output smode,
    output mvalid,
    output split_grant,
    input  srdata,
    input  svalid,
    input  sready,
    input  ssplit
  );

  modport slave (
    input  swdata,
    input  smode,
    input  mvalid,
    input  split_grant,
    output srdata,
    output svalid,
    output sready,
    output ssplit
  );

endinterface

// File: rtl/serial_shift_rx.sv
// LSB-first deserialiser: captures one bit per enabled cycle and
// flags the cycle in which the last bit is taken.
module serial_shift_rx
  import bus_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         bit_i,
  output logic [W-1:0] data_o,
  output logic         done_o
);

  localparam int CW = cnt_w(W);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  data_q, data_d;
  logic          last;

  assign last   = (cnt_q == CW'(W - 1));
  assign done_o = en_i && last;
  assign data_o = data_q;

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (en_i) begin
      data_d[cnt_q] = bit_i;
      cnt_d = last ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      data_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/slave_port.sv
// Slave endpoint: deserialises address/write data, accesses local
// memory (optionally splitting slow reads) and serialises read data.
module slave_port
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH      = SLAVE_MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH      = BUS_DATA_WIDTH,
  parameter bit SPLIT_EN        = 1'b0,
  parameter int SPLIT_THRESHOLD = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  slave_port_if.slave           bus,
  output logic [ADDR_WIDTH-1:0] smemaddr,
  output logic [DATA_WIDTH-1:0] smemwdata,
  output logic                  smemwen,
  output logic                  smemren,
  input  logic [DATA_WIDTH-1:0] smemrdata,
  input  logic                  smemrvalid
);

  localparam int BCW = cnt_w(DATA_WIDTH);
  localparam int WCW = cnt_w(SPLIT_THRESHOLD);

  state_e                state_q, state_d;
  logic                  mode_q, mode_d;
  logic [WCW-1:0]        wcnt_q, wcnt_d;
  logic [BCW-1:0]        bcnt_q, bcnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  srdata_q, srdata_d;
  logic                  svalid_q, svalid_d;
  logic                  ssplit_q, ssplit_d;
  logic                  wen_q, wen_d;
  logic                  ren_q, ren_d;
  logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
  logic [DATA_WIDTH-1:0] mwdata_q, mwdata_d;

  logic                  addr_en, addr_done;
  logic                  data_en, data_done;
  logic [ADDR_WIDTH-1:0] addr_sr, addr_full;
  logic [DATA_WIDTH-1:0] wdata_sr, wdata_full;
  logic                  wait_hit, bcnt_last;

  assign addr_en = bus.mvalid &&
                   (state_q == S_IDLE || state_q == S_ADDR);
  assign data_en = bus.mvalid && (state_q == S_WDATA);

  serial_shift_rx #(.W(ADDR_WIDTH)) u_addr_rx (
    .clk    (clk),
    .rst_n  (rstn),
    .en_i   (addr_en),
    .bit_i  (bus.swdata),
    .data_o (addr_sr),
    .done_o (addr_done)
  );

  serial_shift_rx #(.W(DATA_WIDTH)) u_data_rx (
    .clk    (clk),
    .rst_n  (rstn),
    .en_i   (data_en),
    .bit_i  (bus.swdata),
    .data_o (wdata_sr),
    .done_o (data_done)
  );

  // The MSB is still on the wire in the done cycle.
  assign addr_full  = {bus.swdata, addr_sr[ADDR_WIDTH-2:0]};
  assign wdata_full = {bus.swdata, wdata_sr[DATA_WIDTH-2:0]};

  assign wait_hit  = (wcnt_q == WCW'(SPLIT_THRESHOLD - 1));
  assign bcnt_last = (bcnt_q == BCW'(DATA_WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    wcnt_d   = wcnt_q;
    bcnt_d   = bcnt_q;
    rdata_d  = rdata_q;
    srdata_d = 1'b0;
    svalid_d = 1'b0;
    ssplit_d = 1'b0;
    wen_d    = 1'b0;
    ren_d    = 1'b0;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.mvalid) begin
          mode_d  = bus.smode;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (addr_done) begin
          if (mode_q) begin
            state_d = S_WDATA;
          end else begin
            state_d = S_MEMRD;
            ren_d   = 1'b1;
            maddr_d = addr_full;
            wcnt_d  = '0;
          end
        end
      end
      S_WDATA: begin
        if (data_done) begin
          state_d  = S_MEMWR;
          wen_d    = 1'b1;
          maddr_d  = addr_sr;
          mwdata_d = wdata_full;
        end
      end
      S_MEMWR: begin
        state_d = S_IDLE;
      end
      S_MEMRD: begin
        if (smemrvalid) begin
          rdata_d = smemrdata;
          wcnt_d  = '0;
          state_d = S_RDATA;
        end else if (SPLIT_EN && wait_hit) begin
          ren_d    = 1'b1;
          ssplit_d = 1'b1;
          wcnt_d   = '0;
          state_d  = S_SPLIT;
        end else begin
          ren_d = 1'b1;
          if (!wait_hit) wcnt_d = wcnt_q + WCW'(1);
        end
      end
      S_SPLIT: begin
        // ssplit stays up exactly while the read is outstanding.
        if (ssplit_q) begin
          if (smemrvalid) begin
            rdata_d = smemrdata;
          end else begin
            ren_d    = 1'b1;
            ssplit_d = 1'b1;
          end
        end else if (bus.split_grant) begin
          state_d = S_RDATA;
        end
      end
      S_RDATA: begin
        srdata_d = rdata_q[bcnt_q];
        svalid_d = 1'b1;
        if (bcnt_last) begin
          bcnt_d  = '0;
          state_d = S_IDLE;
        end else begin
          bcnt_d = bcnt_q + BCW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      mode_q   <= 1'b0;
      wcnt_q   <= '0;
      bcnt_q   <= '0;
      rdata_q  <= '0;
      srdata_q <= 1'b0;
      svalid_q <= 1'b0;
      ssplit_q <= 1'b0;
      wen_q    <= 1'b0;
      ren_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      wcnt_q   <= wcnt_d;
      bcnt_q   <= bcnt_d;
      rdata_q  <= rdata_d;
      srdata_q <= srdata_d;
      svalid_q <= svalid_d;
      ssplit_q <= ssplit_d;
      wen_q    <= wen_d;
      ren_q    <= ren_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
    end
  end

  assign bus.srdata = srdata_q;
  assign bus.svalid = svalid_q;
  assign bus.ssplit = ssplit_q;
  assign bus.sready = (state_q == S_IDLE);
  assign smemaddr   = maddr_q;
  assign smemwdata  = mwdata_q;
  assign smemwen    = wen_q;
  assign smemren    = ren_q;

endmodule

// File: tb/tb_slave_port.sv
// Bench for slave_port: directed vector table, reset abort sequence
// and random traffic checked against a simple memory model.
module tb_slave_port;

  localparam int AW  = 12;
  localparam int DW  = 8;
  localparam int THR = 4;
  localparam int NV  = 10;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [AW-1:0] smemaddr;
  logic [DW-1:0] smemwdata;
  logic          smemwen;
  logic          smemren;
  logic [DW-1:0] smemrdata;
  logic          smemrvalid;

  slave_port_if bus();

  slave_port #(
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW),
    .SPLIT_EN        (1'b1),
    .SPLIT_THRESHOLD (THR)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .bus        (bus),
    .smemaddr   (smemaddr),
    .smemwdata  (smemwdata),
    .smemwen    (smemwen),
    .smemren    (smemren),
    .smemrdata  (smemrdata),
    .smemrvalid (smemrvalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [11:0] addr;
    logic [7:0]  data;
    int          lat;
    bit          pre;
    int          gap;
    logic [7:0]  exp_b;
    bit          exp_s;
  } vec_t;

  vec_t vecs[NV];

  int n_cmp = 0;
  int n_bad = 0;
  int wr_cnt = 0;
  int n_wr = 0;
  int rd_lat = 1;
  int rk = 0;

  logic [DW-1:0] mem[1<<AW];
  logic [DW-1:0] exp_mem[1<<AW];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic b, input logic m);
    bus.mvalid = v;
    bus.swdata = b;
    bus.smode  = m;
  endtask

  task automatic send_bits(input logic [15:0] val, input int n,
                           input int gap, input logic mode,
                           input bit is_addr);
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < 3 && $urandom_range(99) < gap; g++) begin
        drv(1'b0, 1'($urandom), 1'($urandom));
        tick();
      end
      drv(1'b1, val[i], (is_addr && i == 0) ? mode : 1'($urandom));
      tick();
    end
    drv(1'b0, 1'b0, 1'b0);
  endtask

  // Local memory: writes on smemwen, read data lat cycles after smemren.
  initial begin
    smemrvalid = 1'b0;
    smemrdata  = '0;
    forever begin
      tick();
      if (smemwen) begin
        mem[smemaddr] = smemwdata;
        wr_cnt++;
      end
      smemrvalid = 1'b0;
      smemrdata  = DW'($urandom);
      if (smemren) begin
        rk++;
        if (rk == rd_lat + 1) begin
          smemrvalid = 1'b1;
          smemrdata  = mem[smemaddr];
        end
      end else begin
        rk = 0;
      end
    end
  end

  task automatic do_write(input logic [11:0] a, input logic [7:0] d,
                          input int gap);
    chk("wr_sready_idle", 32'(bus.sready), 32'd1);
    send_bits(16'(a), AW, gap, 1'b1, 1'b1);
    tick();
    send_bits(16'(d), DW, gap, 1'b0, 1'b0);
    chk("wr_wen", 32'(smemwen), 32'd1);
    chk("wr_addr", 32'(smemaddr), 32'(a));
    chk("wr_data", 32'(smemwdata), 32'(d));
    chk("wr_sready_busy", 32'(bus.sready), 32'd0);
    tick();
    chk("wr_wen_once", 32'(smemwen), 32'd0);
    chk("wr_sready_after", 32'(bus.sready), 32'd1);
    exp_mem[a] = d;
    n_wr++;
  endtask

  task automatic do_read(input logic [11:0] a, input int lat,
                         input logic [7:0] exp_b, input bit exp_s,
                         input int gap);
    int rise, fall, gnt, first;
    logic [7:0] got;
    rd_lat = lat;
    rise = 0; fall = 0; gnt = 0; first = 0;
    got = '0;
    chk("rd_sready_idle", 32'(bus.sready), 32'd1);
    send_bits(16'(a), AW, gap, 1'b0, 1'b1);
    chk("rd_ren", 32'(smemren), 32'd1);
    chk("rd_addr", 32'(smemaddr), 32'(a));
    for (int k = 1; k <= lat + 24 && first == 0; k++) begin
      if (bus.svalid) begin
        first = k;
      end else begin
        if (bus.ssplit && rise == 0) rise = k;
        if (rise != 0 && !bus.ssplit && fall == 0) begin
          fall = k;
          gnt  = k + 2;
        end
        bus.split_grant = (k == rise) || (k == gnt);
        drv(1'($urandom), 1'($urandom), 1'($urandom));
        tick();
      end
    end
    bus.split_grant = 1'b0;
    chk("rd_split_rise", 32'(rise), exp_s ? 32'(THR + 1) : 32'd0);
    chk("rd_split_fall", 32'(fall), exp_s ? 32'(lat + 2) : 32'd0);
    chk("rd_svalid_start", 32'(first),
        exp_s ? 32'(lat + 6) : 32'(lat + 3));
    if (first != 0) begin
      for (int i = 0; i < DW; i++) begin
        chk("rd_svalid_bit", 32'(bus.svalid), 32'd1);
        got[i] = bus.srdata;
        if (i < DW - 1) drv(1'($urandom), 1'($urandom), 1'($urandom));
        else drv(1'b0, 1'b0, 1'b0);
        tick();
      end
      chk("rd_svalid_end", 32'(bus.svalid), 32'd0);
      chk("rd_byte", 32'(got), 32'(exp_b));
    end
    drv(1'b0, 1'b0, 1'b0);
    tick();
  endtask

  initial begin
    logic [11:0] ra;
    logic [7:0]  rd;
    int          rl;

    for (int i = 0; i < (1 << AW); i++) begin
      rd = 8'($urandom);
      mem[i] = rd;
      exp_mem[i] = rd;
    end

    vecs[0] = '{1'b1, 12'h5A3, 8'hC7, 0,  1'b0, 0,  8'h00, 1'b0};
    vecs[1] = '{1'b0, 12'h012, 8'h3C, 2,  1'b1, 0,  8'h3C, 1'b0};
    vecs[2] = '{1'b0, 12'h7E1, 8'h81, 10, 1'b1, 0,  8'h81, 1'b1};
    vecs[3] = '{1'b0, 12'h200, 8'hA5, 3,  1'b1, 0,  8'hA5, 1'b0};
    vecs[4] = '{1'b0, 12'h201, 8'h5A, 4,  1'b1, 0,  8'h5A, 1'b1};
    vecs[5] = '{1'b0, 12'h5A3, 8'h00, 1,  1'b0, 0,  8'hC7, 1'b0};
    vecs[6] = '{1'b1, 12'h000, 8'h00, 0,  1'b0, 0,  8'h00, 1'b0};
    vecs[7] = '{1'b0, 12'h000, 8'h00, 5,  1'b0, 0,  8'h00, 1'b1};
    vecs[8] = '{1'b1, 12'h0AA, 8'h55, 0,  1'b0, 25, 8'h00, 1'b0};
    vecs[9] = '{1'b0, 12'h0AA, 8'h00, 6,  1'b0, 25, 8'h55, 1'b1};

    drv(1'b0, 1'b0, 1'b0);
    bus.split_grant = 1'b0;
    tick();
    chk("rst_srdata", 32'(bus.srdata), 32'd0);
    chk("rst_svalid", 32'(bus.svalid), 32'd0);
    chk("rst_ssplit", 32'(bus.ssplit), 32'd0);
    chk("rst_sready", 32'(bus.sready), 32'd1);
    chk("rst_wen", 32'(smemwen), 32'd0);
    chk("rst_ren", 32'(smemren), 32'd0);
    chk("rst_addr", 32'(smemaddr), 32'd0);
    chk("rst_wdata", 32'(smemwdata), 32'd0);
    tick();
    rstn = 1'b1;
    tick();

    for (int v = 0; v < NV; v++) begin
      if (vecs[v].pre) begin
        mem[vecs[v].addr] = vecs[v].data;
        exp_mem[vecs[v].addr] = vecs[v].data;
      end
      if (vecs[v].wr) do_write(vecs[v].addr, vecs[v].data, vecs[v].gap);
      else do_read(vecs[v].addr, vecs[v].lat, vecs[v].exp_b,
                   vecs[v].exp_s, vecs[v].gap);
    end

    // Abort a write while address bit 7 is on the wire.
    ra = 12'h3C5;
    for (int i = 0; i < 7; i++) begin
      drv(1'b1, ra[i], (i == 0) ? 1'b1 : 1'($urandom));
      tick();
    end
    drv(1'b1, ra[7], 1'b0);
    #3 rstn = 1'b0;
    #1;
    chk("arst_srdata", 32'(bus.srdata), 32'd0);
    chk("arst_svalid", 32'(bus.svalid), 32'd0);
    chk("arst_ssplit", 32'(bus.ssplit), 32'd0);
    chk("arst_sready", 32'(bus.sready), 32'd1);
    chk("arst_wen", 32'(smemwen), 32'd0);
    chk("arst_ren", 32'(smemren), 32'd0);
    chk("arst_addr", 32'(smemaddr), 32'd0);
    chk("arst_wdata", 32'(smemwdata), 32'd0);
    drv(1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rstn = 1'b1;
    tick();
    tick();
    do_write(12'hFFF, 8'hFF, 0);
    do_read(12'hFFF, 2, 8'hFF, 1'b0, 0);

    for (int t = 0; t < 24; t++) begin
      ra = 12'($urandom);
      if ($urandom_range(1) == 1) begin
        do_write(ra, 8'($urandom), 25);
      end else begin
        rl = int'($urandom_range(9, 1));
        do_read(ra, rl, exp_mem[ra], (rl + 1 > THR), 25);
      end
    end

    tick();
    chk("write_count", 32'(wr_cnt), 32'(n_wr));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
